xctrl_p: RTL

XCTRL_P -- requirements
Module: xctrl_p

---
 rtl/xctrl_p.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/xctrl_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : xctrl_p                                                          |
// | Brief   : Small accumulator-based controller. It has a 2*DATA_W base       |
// |           register, a carry flag, a call stack, and a RUN/WAIT/HALT        |
// |           sequencer for external data accesses.                            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module xctrl_p #(
  parameter int                     DATA_W      = 32,
  parameter int                     ADDR_W      = 12,
  parameter int                     PROG_ADDR_W = 10,
  parameter int                     IMM_W       = 16,
  parameter int                     STACK_D     = 4,
  parameter logic [PROG_ADDR_W-1:0] RST_PC      = '0,
  parameter logic [ADDR_W-1:0]      RB0_A       = 12'h0F0,
  parameter logic [ADDR_W-1:0]      RB1_A       = 12'h0F1,
  parameter logic [ADDR_W-1:0]      RC_A        = 12'h0F2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PROG_ADDR_W-1:0] pc,
  input  logic [IMM_W+4:0]       instruction,
  output logic                   data_sel,
  output logic                   data_we,
  output logic [ADDR_W-1:0]      data_addr,
  input  logic [DATA_W-1:0]      data_to_rd,
  input  logic                   data_ack,
  output logic [DATA_W-1:0]      data_to_wr,
  output logic                   fault
);

  localparam logic [4:0] OP_LDI   = 5'd4;
  localparam logic [4:0] OP_LDIH  = 5'd5;
  localparam logic [4:0] OP_ADD   = 5'd6;
  localparam logic [4:0] OP_ADDI  = 5'd7;
  localparam logic [4:0] OP_SUB   = 5'd8;
  localparam logic [4:0] OP_AND   = 5'd9;
  localparam logic [4:0] OP_XOR   = 5'd10;
  localparam logic [4:0] OP_SHFT  = 5'd11;
  localparam logic [4:0] OP_BEQI  = 5'd12;
  localparam logic [4:0] OP_BNEQI = 5'd13;
  localparam logic [4:0] OP_BEQ   = 5'd14;
  localparam logic [4:0] OP_BNEQ  = 5'd15;
  localparam logic [4:0] OP_CALL  = 5'd16;
  localparam logic [4:0] OP_RET   = 5'd17;

  localparam int SP_W  = $clog2(STACK_D + 1);
  localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;
  localparam logic [SP_W-1:0]   SP_FULL = SP_W'(STACK_D);
  // Keeps the low IMM_W bits of A for LDIH; all ones when DATA_W == IMM_W
  localparam logic [DATA_W-1:0] LO_MASK = {DATA_W{1'b1}} >> (DATA_W - IMM_W);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PROG_ADDR_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0]       a_q, a_d;
  logic [2*DATA_W-1:0]     b_q, b_d;
  logic                    carry_q, carry_d;
  logic [SP_W-1:0]         sp_q, sp_d;
  logic                    fault_q, fault_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    wr_q, wr_d;
  logic [PROG_ADDR_W-1:0]  stack_q [STACK_D];
  logic [PROG_ADDR_W-1:0]  stack_d [STACK_D];

  logic [4:0]              opcode;
  logic signed [IMM_W-1:0] operand;
  logic [DATA_W-1:0]       imm;
  logic                    is_mem, is_wr, is_int, taken;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       int_rd;
  logic [DATA_W:0]         sum;
  logic [PROG_ADDR_W-1:0]  pc_inc, pc_rel;
  logic [IDX_W-1:0]        push_idx, pop_idx;

  assign opcode   = instruction[IMM_W+4:IMM_W];
  assign operand  = instruction[IMM_W-1:0];
  assign imm      = DATA_W'(operand);
  // Opcodes 0..3 are the memory group: bit0 selects based addressing, bit1 write
  assign is_mem   = (opcode[4:2] == 3'b000);
  assign is_wr    = opcode[1];
  assign mem_addr = opcode[0] ? (b_q[ADDR_W-1:0] + imm[ADDR_W-1:0]) : imm[ADDR_W-1:0];
  assign is_int   = (mem_addr == RB0_A) || (mem_addr == RB1_A) || (mem_addr == RC_A);
  assign int_rd   = (mem_addr == RB0_A) ? b_q[DATA_W-1:0] :
                    (mem_addr == RB1_A) ? b_q[2*DATA_W-1:DATA_W] : DATA_W'(carry_q);
  assign pc_inc   = pc_q + PROG_ADDR_W'(1);
  assign pc_rel   = pc_q + imm[PROG_ADDR_W-1:0];
  assign push_idx = sp_q[IDX_W-1:0];
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));
  // Odd opcodes in the branch group test for nonzero, even ones for zero
  assign taken    = opcode[0] ? (a_q != '0) : (a_q == '0);

  assign pc         = pc_q;
  assign data_to_wr = a_q;
  assign fault      = fault_q;

  // External access request: live in RUN, frozen from the latched copy in WAIT
  always_comb begin
    data_sel  = 1'b0;
    data_we   = 1'b0;
    data_addr = (state_q == ST_WAIT) ? addr_q : mem_addr;
    if (!rst) begin
      if (state_q == ST_RUN && is_mem && !is_int) begin
        data_sel = 1'b1;
        data_we  = is_wr;
      end else if (state_q == ST_WAIT) begin
        data_sel = 1'b1;
        data_we  = wr_q;
      end
    end
  end

  // Instruction execution and sequencer next-state
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sp_d    = sp_q;
    fault_d = fault_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    stack_d = stack_q;
    sum     = '0;
    case (state_q)
      ST_RUN: begin
        if (is_mem) begin
          if (is_int) begin
            pc_d = pc_inc;
            if (!is_wr)                 a_d = int_rd;
            else if (mem_addr == RB0_A) b_d[DATA_W-1:0] = a_q;
            else if (mem_addr == RB1_A) b_d[2*DATA_W-1:DATA_W] = a_q;
          end else if (data_ack) begin
            pc_d = pc_inc;
            if (!is_wr) a_d = data_to_rd;
          end else begin
            state_d = ST_WAIT;
            addr_d  = mem_addr;
            wr_d    = is_wr;
          end
        end else begin
          pc_d = pc_inc;
          case (opcode)
            OP_LDI:  a_d = imm;
            OP_LDIH: a_d = (imm << IMM_W) | (a_q & LO_MASK);
            OP_ADD: begin
              sum = {1'b0, a_q} + {1'b0, b_q[DATA_W-1:0]};
              a_d = sum[DATA_W-1:0];  carry_d = sum[DATA_W];
            end
            OP_ADDI: begin
              sum = {1'b0, a_q} + {1'b0, imm};
              a_d = sum[DATA_W-1:0];  carry_d = sum[DATA_W];
            end
            OP_SUB: begin
              sum = {1'b0, a_q} - {1'b0, b_q[DATA_W-1:0]};
              a_d = sum[DATA_W-1:0];  carry_d = sum[DATA_W];
            end
            OP_AND:  a_d = a_q & b_q[DATA_W-1:0];
            OP_XOR:  a_d = a_q ^ b_q[DATA_W-1:0];
            OP_SHFT: begin
              if (imm[DATA_W-1]) begin
                a_d = a_q << 1;  carry_d = a_q[DATA_W-1];
              end else begin
                a_d = a_q >> 1;  carry_d = a_q[0];
              end
            end
            OP_BEQI, OP_BNEQI, OP_BEQ, OP_BNEQ: begin
              a_d = a_q - DATA_W'(1);
              if (taken) pc_d = opcode[1] ? b_q[PROG_ADDR_W-1:0] : pc_rel;
            end
            OP_CALL: begin
              if (sp_q == SP_FULL) begin
                pc_d = pc_q;  state_d = ST_HALT;  fault_d = 1'b1;
              end else begin
                stack_d[push_idx] = pc_inc;
                sp_d = sp_q + SP_W'(1);
                pc_d = pc_rel;
              end
            end
            OP_RET: begin
              if (sp_q == '0) begin
                pc_d = pc_q;  state_d = ST_HALT;  fault_d = 1'b1;
              end else begin
                pc_d = stack_q[pop_idx];
                sp_d = sp_q - SP_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
      ST_WAIT: begin
        if (data_ack) begin
          if (!wr_q) a_d = data_to_rd;
          pc_d    = pc_inc;
          state_d = ST_RUN;
        end
      end
      default: ;
    endcase
  end

  // State registers; reset abandons any pending access and clears the stack
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RST_PC;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sp_q    <= '0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sp_q    <= sp_d;
      fault_q <= fault_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
    end
    stack_q <= stack_d;
  end

endmodule
`default_nettype wire
